// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one add/sub/and/xor ALU between two requesters.
// Round-robin grant, registered ALU drive, captured result and Y86-64 CCs.
module alu_share_ctrl #(
    parameter int WIDTH = 64,
    parameter int NFUN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_fun,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_fun,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_sum,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_cc,
    output logic             rsp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;

    localparam int MSB = WIDTH - 1;

    logic [1:0]       r_state;
    logic             r_ptr;
    logic             r_gnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_fun;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_cc;
    logic             r_err;

    logic             w_idle;
    logic             w_resp;
    logic             w_any;
    logic             w_gnt_id;
    logic             w_fire;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [3:0]       w_sel_fun;
    logic             w_fun_ok;
    logic             w_rsp_hs;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;

    // Arbitration: a lone requester wins, otherwise the pointer decides.
    always_comb begin
        w_idle   = (r_state == ST_IDLE);
        w_resp   = (r_state == ST_RESP);
        w_any    = req0_valid | req1_valid;
        w_gnt_id = (req0_valid & req1_valid) ? r_ptr : req1_valid;
        w_fire   = rst_n & w_idle & w_any;
    end

    // Ready is only ever offered to the winner, and never while in reset.
    always_comb begin
        req0_ready = w_fire & ~w_gnt_id;
        req1_ready = w_fire & w_gnt_id;
    end

    // Operand mux from the winning requester and legality of its function.
    always_comb begin
        w_sel_a   = w_gnt_id ? req1_a : req0_a;
        w_sel_b   = w_gnt_id ? req1_b : req0_b;
        w_sel_fun = w_gnt_id ? req1_fun : req0_fun;
        w_fun_ok  = ({28'd0, w_sel_fun} < 32'(NFUN));
    end

    // Condition codes from the live ALU result and the latched operands.
    always_comb begin
        w_zf = (alu_sum == '0);
        w_sf = alu_sum[MSB];
        w_of = 1'b0;
        unique case (1'b1)
            (r_fun == FN_ADD):
                w_of = (r_a[MSB] == r_b[MSB]) & (alu_sum[MSB] != r_a[MSB]);
            (r_fun == FN_SUB):
                w_of = (r_a[MSB] != r_b[MSB]) & (alu_sum[MSB] != r_a[MSB]);
            default:
                w_of = 1'b0;
        endcase
    end

    // Response channel steering and handshake detect.
    always_comb begin
        rsp0_valid = w_resp & ~r_gnt;
        rsp1_valid = w_resp & r_gnt;
        w_rsp_hs   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
    end

    // Sequencer: IDLE -> EXEC -> RESP, or IDLE -> RESP for bad function codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_gnt   <= w_gnt_id;
                        r_state <= w_fun_ok ? ST_EXEC : ST_RESP;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_ptr   <= ~r_gnt;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU drive registers; a rejected function code leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_fun <= '0;
        end else if (w_fire && w_fun_ok) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_fun <= w_sel_fun;
        end
    end

    // Result capture, held until the response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cc   <= '0;
            r_err  <= 1'b0;
        end else if (w_fire && !w_fun_ok) begin
            r_data <= '0;
            r_cc   <= '0;
            r_err  <= 1'b1;
        end else if (r_state == ST_EXEC) begin
            r_data <= alu_sum;
            r_cc   <= {w_zf, w_sf, w_of};
            r_err  <= 1'b0;
        end
    end

    // Registered outputs.
    always_comb begin
        alu_a    = r_a;
        alu_b    = r_b;
        alu_sel  = r_fun;
        rsp_data = r_data;
        rsp_cc   = r_cc;
        rsp_err  = r_err;
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and random checks of alu_share_ctrl
// against an arithmetic reference of the ALU and condition codes.
module tb_alu_share_ctrl;

    localparam int W = 64;
    localparam logic signed [64:0] SMAX = 65'sd9223372036854775807;
    localparam logic signed [64:0] SMIN = -65'sd9223372036854775808;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [3:0]   req0_fun;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [3:0]   req1_fun;
    logic [W-1:0] alu_a, alu_b, alu_sum;
    logic [3:0]   alu_sel;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_data;
    logic [2:0]   rsp_cc;
    logic         rsp_err;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    alu_share_ctrl #(.WIDTH(W), .NFUN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_sum(alu_sum),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_cc(rsp_cc), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The shared ALU datapath.
    always_comb begin
        case (alu_sel)
            4'd0:    alu_sum = alu_a + alu_b;
            4'd1:    alu_sum = alu_a - alu_b;
            4'd2:    alu_sum = alu_a & alu_b;
            4'd3:    alu_sum = alu_a ^ alu_b;
            default: alu_sum = '0;
        endcase
    end

    // Reference: exact signed arithmetic, overflow = out of 64-bit range.
    task automatic ref_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] f, output logic [63:0] r,
                          output logic [2:0] cc, output logic e);
        logic signed [64:0] x, y, s;
        logic of;
        x = $signed({a[63], a});
        y = $signed({b[63], b});
        of = 1'b0;
        e = 1'b0;
        r = '0;
        case (f)
            4'd0: begin s = x + y; r = s[63:0]; of = (s > SMAX) || (s < SMIN); end
            4'd1: begin s = x - y; r = s[63:0]; of = (s > SMAX) || (s < SMIN); end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            default: e = 1'b1;
        endcase
        if (e) cc = 3'b000;
        else   cc = {r == 64'd0, r[63], of};
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 15));
            default: return rnd64();
        endcase
    endfunction

    task automatic drive(input bit id, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] f);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_fun = f;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_fun = f;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one op and reports wait-for-ready and response latency.
    task automatic run_op(input bit id, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] f,
                          output int wt, output int lat,
                          output logic [63:0] d, output logic [2:0] cc,
                          output logic e);
        wt = -1; lat = -1; d = '0; cc = '0; e = 1'b0;
        @(negedge clk);
        drive(id, 1'b1, a, b, f);
        #1;
        for (int n = 0; n < 20; n++) begin
            if (id ? req1_ready : req0_ready) begin
                wt = n;
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk);
        drive(id, 1'b0, '0, '0, '0);
        if (wt < 0) return;
        #1;
        for (int n = 1; n < 20; n++) begin
            if (id ? rsp1_valid : rsp0_valid) begin
                lat = n; d = rsp_data; cc = rsp_cc; e = rsp_err;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 64'd1, 64'd2, 4'd0);
        drive(1'b1, 1'b1, 64'd3, 64'd4, 4'd1);
        #12;
        nvec++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err,
             rsp_cc, rsp_data, alu_a, alu_b, alu_sel} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: rdy=%b%b vld=%b%b data=%h sel=%h",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                     rsp_data, alu_sel);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int wt, lat;
        logic [63:0] d;
        logic [2:0] cc;
        logic e;
        run_op(1'b0, 64'd5, 64'd7, 4'd0, wt, lat, d, cc, e);
        nvec++;
        if (wt !== 0) begin nerr++; $display("FAIL basic_ready: got %0d exp 0", wt); end
        nvec++;
        if (lat !== 2) begin nerr++; $display("FAIL basic_lat: got %0d exp 2", lat); end
        nvec++;
        if (d !== 64'd12) begin nerr++; $display("FAIL basic_data: got %h exp c", d); end
        nvec++;
        if (cc !== 3'b000 || e !== 1'b0) begin
            nerr++; $display("FAIL basic_cc: got cc=%b err=%b exp 000/0", cc, e);
        end
        nvec++;
        if ({alu_a, alu_b, alu_sel} !== {64'd5, 64'd7, 4'd0}) begin
            nerr++; $display("FAIL basic_alu_hold: got %h %h %h", alu_a, alu_b, alu_sel);
        end
    endtask

    task automatic test_cc();
        bit          ti [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] ta [4] = '{64'd3, 64'h8000_0000_0000_0000,
                                64'h7FFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0};
        logic [63:0] tb [4] = '{64'd3, 64'd1,
                                64'h7FFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0};
        logic [3:0]  tf [4] = '{4'd1, 4'd1, 4'd0, 4'd3};
        int wt, lat;
        logic [63:0] d, ed;
        logic [2:0] cc, ecc;
        logic e, ee;
        for (int i = 0; i < 4; i++) begin
            ref_op(ta[i], tb[i], tf[i], ed, ecc, ee);
            run_op(ti[i], ta[i], tb[i], tf[i], wt, lat, d, cc, e);
            nvec++;
            if (d !== ed) begin nerr++; $display("FAIL cc%0d_data: got %h exp %h", i, d, ed); end
            nvec++;
            if (cc !== ecc) begin nerr++; $display("FAIL cc%0d_flags: got %b exp %b", i, cc, ecc); end
            nvec++;
            if (lat !== 2 || e !== 1'b0) begin
                nerr++; $display("FAIL cc%0d_lat: got lat=%0d err=%b exp 2/0", i, lat, e);
            end
        end
    endtask

    task automatic test_illegal();
        int wt, lat;
        logic [63:0] d;
        logic [2:0] cc;
        logic e;
        logic [3:0] sel0;
        sel0 = alu_sel;
        run_op(1'b0, rnd64(), rnd64(), 4'h9, wt, lat, d, cc, e);
        nvec++;
        if (lat !== 1) begin nerr++; $display("FAIL illegal_lat: got %0d exp 1", lat); end
        nvec++;
        if ({e, cc, d} !== {1'b1, 3'b000, 64'd0}) begin
            nerr++; $display("FAIL illegal_rsp: got err=%b cc=%b d=%h exp 1/000/0", e, cc, d);
        end
        nvec++;
        if (alu_sel !== sel0) begin nerr++; $display("FAIL illegal_sel: got %h exp %h", alu_sel, sel0); end
    endtask

    task automatic test_fairness();
        logic [63:0] ca [2];
        logic [63:0] cb [2];
        logic [3:0]  cf [2];
        int order [$];
        int gcy [$];
        bit pend, pid, gnow, gid;
        logic [63:0] pd;
        logic [2:0] pcc;
        logic pe;
        do_reset();
        pend = 1'b0; pid = 1'b0; gid = 1'b0;
        pd = '0; pcc = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ca[i] = rnd64(); cb[i] = rnd64(); cf[i] = 4'($urandom_range(0, 3));
            drive(i[0], 1'b1, ca[i], cb[i], cf[i]);
        end
        for (int c = 0; c < 60; c++) begin
            #1;
            gnow = 1'b0;
            if (rsp0_valid || rsp1_valid) begin
                nvec++;
                if (!pend || rsp1_valid !== pid || rsp_data !== pd || rsp_cc !== pcc) begin
                    nerr++;
                    $display("FAIL fair_rsp: got id=%b d=%h cc=%b exp id=%b d=%h cc=%b",
                             rsp1_valid, rsp_data, rsp_cc, pid, pd, pcc);
                end
                pend = 1'b0;
            end
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
                gnow = 1'b1;
                order.push_back(int'(gid));
                gcy.push_back(cyc);
                ref_op(ca[gid], cb[gid], cf[gid], pd, pcc, pe);
                pid = gid;
                pend = 1'b1;
            end
            @(negedge clk);
            if (gnow) begin
                if (order.size() < 6) begin
                    ca[gid] = rnd64(); cb[gid] = rnd64();
                    cf[gid] = 4'($urandom_range(0, 3));
                    drive(gid, 1'b1, ca[gid], cb[gid], cf[gid]);
                end else begin
                    drive(1'b0, 1'b0, '0, '0, '0);
                    drive(1'b1, 1'b0, '0, '0, '0);
                end
            end
            if (order.size() >= 6 && !pend) break;
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        nvec++;
        if (order.size() !== 6 || pend) begin
            nerr++; $display("FAIL fair_count: got %0d grants exp 6", order.size());
        end
        for (int k = 0; k < order.size() && k < 6; k++) begin
            nvec++;
            if (order[k] !== k % 2) begin
                nerr++; $display("FAIL fair_order%0d: got %0d exp %0d", k, order[k], k % 2);
            end
            if (k > 0) begin
                nvec++;
                if (gcy[k] - gcy[k-1] !== 3) begin
                    nerr++; $display("FAIL fair_gap%0d: got %0d exp 3", k, gcy[k] - gcy[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, ed, d0;
        logic [2:0] ecc;
        logic ee;
        bit got;
        a = rnd64(); b = rnd64();
        ref_op(a, b, 4'd0, ed, ecc, ee);
        rsp0_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, a, b, 4'd0);
        #1;
        nvec++;
        if (req0_ready !== 1'b1) begin nerr++; $display("FAIL bp_accept: got %b exp 1", req0_ready); end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b1, 64'd100, 64'd1, 4'd1);
        @(negedge clk); #1;
        d0 = rsp_data;
        nvec++;
        if (rsp0_valid !== 1'b1 || d0 !== ed || rsp_cc !== ecc) begin
            nerr++; $display("FAIL bp_first: got v=%b d=%h cc=%b exp 1 %h %b",
                             rsp0_valid, d0, rsp_cc, ed, ecc);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            nvec++;
            if (rsp0_valid !== 1'b1 || rsp_data !== d0 || req1_ready !== 1'b0) begin
                nerr++; $display("FAIL bp_hold%0d: got v=%b d=%h r1=%b exp 1 %h 0",
                                 c, rsp0_valid, rsp_data, req1_ready, d0);
            end
        end
        @(negedge clk);
        rsp0_ready = 1'b1;
        #1;
        nvec++;
        if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0) begin
            nerr++; $display("FAIL bp_hs: got v=%b r1=%b exp 1 0", rsp0_valid, req1_ready);
        end
        @(negedge clk); #1;
        nvec++;
        if (req1_ready !== 1'b1) begin nerr++; $display("FAIL bp_next: got %b exp 1", req1_ready); end
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, '0);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp1_valid) begin got = 1'b1; d0 = rsp_data; break; end
            @(negedge clk);
        end
        nvec++;
        if (!got || d0 !== 64'd99) begin nerr++; $display("FAIL bp_req1: got %b/%h exp 1/63", got, d0); end
    endtask

    task automatic test_reset_mid();
        int wt, lat;
        logic [63:0] d;
        logic [2:0] cc;
        logic e;
        bit seen, got;
        run_op(1'b0, 64'd10, 64'd20, 4'd0, wt, lat, d, cc, e);
        nvec++;
        if (d !== 64'd30) begin nerr++; $display("FAIL rm_pre: got %h exp 1e", d); end
        @(negedge clk);
        drive(1'b1, 1'b1, 64'd1, 64'd2, 4'd0);
        #1;
        nvec++;
        if (req1_ready !== 1'b1) begin nerr++; $display("FAIL rm_accept: got %b exp 1", req1_ready); end
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err,
             rsp_cc, rsp_data, alu_a, alu_b, alu_sel} !== '0) begin
            nerr++; $display("FAIL rm_zero: got a=%h b=%h sel=%h data=%h",
                             alu_a, alu_b, alu_sel, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
            @(negedge clk);
        end
        nvec++;
        if (seen) begin nerr++; $display("FAIL rm_no_rsp: got 1 exp 0"); end
        drive(1'b0, 1'b1, 64'd4, 64'd9, 4'd3);
        drive(1'b1, 1'b1, 64'd6, 64'd6, 4'd2);
        #1;
        nvec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            nerr++; $display("FAIL rm_grant: got %b%b exp 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp0_valid) begin got = 1'b1; d = rsp_data; break; end
            @(negedge clk);
        end
        nvec++;
        if (!got || d !== 64'd13) begin nerr++; $display("FAIL rm_rsp: got %b/%h exp 1/d", got, d); end
    endtask

    task automatic test_random();
        int wt, lat, elat;
        bit id;
        logic [63:0] a, b, d, ed;
        logic [3:0] f;
        logic [2:0] cc, ecc;
        logic e, ee;
        for (int i = 0; i < 40; i++) begin
            id = 1'($urandom_range(0, 1));
            a = rnd_opnd();
            b = ($urandom_range(0, 3) == 0) ? a : rnd_opnd();
            f = ($urandom_range(0, 5) < 5) ? 4'($urandom_range(0, 3))
                                           : 4'($urandom_range(4, 15));
            ref_op(a, b, f, ed, ecc, ee);
            elat = ee ? 1 : 2;
            run_op(id, a, b, f, wt, lat, d, cc, e);
            nvec++;
            if (d !== ed) begin nerr++; $display("FAIL rnd%0d_data: got %h exp %h", i, d, ed); end
            nvec++;
            if (cc !== ecc) begin nerr++; $display("FAIL rnd%0d_cc: got %b exp %b", i, cc, ecc); end
            nvec++;
            if (e !== ee) begin nerr++; $display("FAIL rnd%0d_err: got %b exp %b", i, e, ee); end
            nvec++;
            if (wt !== 0 || lat !== elat) begin
                nerr++; $display("FAIL rnd%0d_lat: got %0d/%0d exp 0/%0d", i, wt, lat, elat);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        test_reset();
        test_basic();
        test_cc();
        test_illegal();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
